// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: event-mode
// encodings and the debounce counter width helper.
package edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Counter must hold 0..DEB_CNT-1; keep at least one bit so the
    // no-debounce configurations still elaborate a legal vector.
    function automatic int cnt_width(input int deb_cnt);
        int w;
        w = $clog2(deb_cnt + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One input channel: synchroniser chain, debounce counter, accepted level,
// single-cycle rise/fall pulses and a sticky, mode-qualified event flag.
module edge_chan
    import edge_pkg::*;
#(
    parameter int   SYNC_STG = 2,
    parameter int   DEB_CNT  = 16,
    parameter logic INIT_LVL = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sig,
    input  logic [1:0] i_mode,
    input  logic       i_clr,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_evt
);

    localparam int CNT_W    = cnt_width(DEB_CNT);
    // With DEB_CNT <= 1 the first mismatching cycle is accepted, so the
    // level simply follows the synchronised input one register later.
    localparam int DEB_LAST = (DEB_CNT <= 1) ? 0 : DEB_CNT - 1;

    logic [SYNC_STG-1:0] r_sync;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_level;
    logic                r_rise;
    logic                r_fall;
    logic                r_evt;

    logic                w_s;
    logic                w_diff;
    logic                w_accept;
    logic                w_evt_set;

    assign w_s      = r_sync[SYNC_STG-1];
    assign w_diff   = (w_s != r_level);
    assign w_accept = w_diff && (r_cnt == CNT_W'(DEB_LAST));

    // Event enable is taken from the mode present while the pulse is high,
    // so a mode change only affects edges that come after it.
    assign w_evt_set = (r_rise && (i_mode == MODE_RISE || i_mode == MODE_BOTH)) ||
                       (r_fall && (i_mode == MODE_FALL || i_mode == MODE_BOTH));

    // Synchroniser shift register; the last stage feeds the debouncer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STG{INIT_LVL}};
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_sig};
        end
    end

    // Debounce: count consecutive mismatching cycles, accept after DEB_CNT.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= INIT_LVL;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= w_s;
        end else if (w_diff) begin
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_cnt   <= '0;
        end
    end

    // Edge pulses line up with the first cycle the new level is visible.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept &  w_s;
            r_fall <= w_accept & ~w_s;
        end
    end

    // Sticky event flag; a set in the same cycle as a clear takes priority.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_evt <= 1'b0;
        end else if (w_evt_set) begin
            r_evt <= 1'b1;
        end else if (i_clr) begin
            r_evt <= 1'b0;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_evt   = r_evt;

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel debounced edge detector: CH_NUM independent edge_chan
// instances plus the combined event indication.
module edge_detect_mc
    import edge_pkg::*;
#(
    parameter int   CH_NUM   = 4,
    parameter int   SYNC_STG = 2,
    parameter int   DEB_CNT  = 16,
    parameter logic INIT_LVL = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [CH_NUM-1:0]     sig_in,
    input  logic [2*CH_NUM-1:0]   mode,
    input  logic [CH_NUM-1:0]     evt_clr,
    output logic [CH_NUM-1:0]     level_out,
    output logic [CH_NUM-1:0]     rise_flag,
    output logic [CH_NUM-1:0]     fall_flag,
    output logic [CH_NUM-1:0]     evt_flag,
    output logic                  evt_any
);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        edge_chan #(
            .SYNC_STG (SYNC_STG),
            .DEB_CNT  (DEB_CNT),
            .INIT_LVL (INIT_LVL)
        ) u_chan (
            .i_clk   (sys_clk),
            .i_rst_n (sys_rst_n),
            .i_sig   (sig_in[g]),
            .i_mode  (mode[2*g +: 2]),
            .i_clr   (evt_clr[g]),
            .o_level (level_out[g]),
            .o_rise  (rise_flag[g]),
            .o_fall  (fall_flag[g]),
            .o_evt   (evt_flag[g])
        );
    end

    assign evt_any = |evt_flag;

endmodule

// File: tb/tb_edge_detect_mc.sv
// Directed bench: a table of per-cycle vectors on a no-debounce instance,
// plus hand-written multi-cycle sequences on a DEB_CNT=16 instance.
module tb_edge_detect_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: DEB_CNT = 16
    logic       a_rst_n = 1'b0;
    logic [3:0] a_sig   = 4'hF;
    logic [7:0] a_mode  = 8'h00;
    logic [3:0] a_clr   = 4'h0;
    logic [3:0] a_lvl, a_rise, a_fall, a_evt;
    logic       a_any;

    // Instance B: DEB_CNT = 0
    logic       b_rst_n = 1'b0;
    logic [3:0] b_sig   = 4'hF;
    logic [7:0] b_mode  = 8'hFF;
    logic [3:0] b_clr   = 4'h0;
    logic [3:0] b_lvl, b_rise, b_fall, b_evt;
    logic       b_any;

    edge_detect_mc #(.CH_NUM(4), .SYNC_STG(2), .DEB_CNT(16), .INIT_LVL(1'b1)) u_deb (
        .sys_clk(clk), .sys_rst_n(a_rst_n), .sig_in(a_sig), .mode(a_mode),
        .evt_clr(a_clr), .level_out(a_lvl), .rise_flag(a_rise),
        .fall_flag(a_fall), .evt_flag(a_evt), .evt_any(a_any)
    );

    edge_detect_mc #(.CH_NUM(4), .SYNC_STG(2), .DEB_CNT(0), .INIT_LVL(1'b1)) u_fast (
        .sys_clk(clk), .sys_rst_n(b_rst_n), .sig_in(b_sig), .mode(b_mode),
        .evt_clr(b_clr), .level_out(b_lvl), .rise_flag(b_rise),
        .fall_flag(b_fall), .evt_flag(b_evt), .evt_any(b_any)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] sig;
        logic [7:0] mode;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] evt;
        logic       any;
    } vec_t;

    vec_t tbl[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive a low pulse of len cycles on ch1, then observe a window and
    // count ch1 pulses and cycles spent at level 0.
    task automatic pulse_ch1(input int len, output int nr, output int nf, output int nlow);
        nr = 0; nf = 0; nlow = 0;
        a_sig[1] = 1'b0;
        for (int i = 0; i < len; i++) begin
            tick();
            nr += int'(a_rise[1]); nf += int'(a_fall[1]); nlow += int'(!a_lvl[1]);
        end
        a_sig[1] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            nr += int'(a_rise[1]); nf += int'(a_fall[1]); nlow += int'(!a_lvl[1]);
        end
    endtask

    initial begin
        int  nr, nf, nlow;
        bit  found;

        // ---------------- table on the no-debounce instance ----------------
        //            rst  sig   mode   clr    lvl   rise  fall  evt   any
        tbl[0]  = '{1'b0, 4'hF, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{1'b1, 4'h0, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[2]  = '{1'b1, 4'h0, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{1'b1, 4'h0, 8'hFF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};
        tbl[4]  = '{1'b1, 4'h0, 8'hFF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1};
        tbl[5]  = '{1'b1, 4'hF, 8'hFF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[6]  = '{1'b1, 4'hF, 8'hFF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[7]  = '{1'b1, 4'hF, 8'hFF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
        tbl[8]  = '{1'b1, 4'hF, 8'hFF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1};
        tbl[9]  = '{1'b1, 4'hF, 8'h00, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[10] = '{1'b1, 4'hE, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{1'b1, 4'hE, 8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[12] = '{1'b1, 4'hE, 8'h00, 4'h0, 4'hE, 4'h0, 4'h1, 4'h0, 1'b0};
        tbl[13] = '{1'b1, 4'hE, 8'h00, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 1'b0};

        tick();
        for (int v = 0; v < 14; v++) begin
            b_rst_n = tbl[v].rst_n;
            b_sig   = tbl[v].sig;
            b_mode  = tbl[v].mode;
            b_clr   = tbl[v].clr;
            tick();
            chk($sformatf("v%0d level_out", v), 32'(b_lvl),  32'(tbl[v].lvl));
            chk($sformatf("v%0d rise_flag", v), 32'(b_rise), 32'(tbl[v].rise));
            chk($sformatf("v%0d fall_flag", v), 32'(b_fall), 32'(tbl[v].fall));
            chk($sformatf("v%0d evt_flag",  v), 32'(b_evt),  32'(tbl[v].evt));
            chk($sformatf("v%0d evt_any",   v), 32'(b_any),  32'(tbl[v].any));
        end

        // ---------------- debounced instance: reset and idle ----------------
        a_rst_n = 1'b0; a_sig = 4'hF; a_mode = 8'b00_01_11_10; a_clr = 4'h0;
        tick(); tick();
        a_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle", {a_lvl, a_rise, a_fall, a_evt, 3'b000, a_any}, {4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
        end

        // ch0 clean 1->0 step: fall after SYNC_STG+DEB_CNT = 18 edges
        a_sig[0] = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk($sformatf("step wait %0d lvl0/fall0", i), {a_lvl[0], a_fall[0]}, 2'b10);
        end
        tick();
        chk("step level0", 32'(a_lvl[0]), 32'd0);
        chk("step fall0 pulse", 32'(a_fall[0]), 32'd1);
        chk("step evt0 not yet", 32'(a_evt[0]), 32'd0);
        tick();
        chk("step fall0 single", 32'(a_fall[0]), 32'd0);
        chk("step evt0 set", 32'(a_evt[0]), 32'd1);
        chk("step evt_any", 32'(a_any), 32'd1);

        // ch1 glitches: 15 cycles rejected, 16 accepted
        pulse_ch1(15, nr, nf, nlow);
        chk("glitch15 rises", 32'(nr), 32'd0);
        chk("glitch15 falls", 32'(nf), 32'd0);
        chk("glitch15 low cycles", 32'(nlow), 32'd0);
        chk("glitch15 evt1", 32'(a_evt[1]), 32'd0);
        pulse_ch1(16, nr, nf, nlow);
        chk("pulse16 rises", 32'(nr), 32'd1);
        chk("pulse16 falls", 32'(nf), 32'd1);
        chk("pulse16 level back", 32'(a_lvl[1]), 32'd1);
        chk("pulse16 evt1", 32'(a_evt[1]), 32'd1);

        // ch2 mode 01: fall ignored, rise sets despite concurrent clear
        a_sig[2] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (a_fall[2]) found = 1'b1;
        end
        chk("ch2 fall seen", 32'(found), 32'd1);
        tick(); tick();
        chk("ch2 fall no evt", 32'(a_evt[2]), 32'd0);
        a_sig[2] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (a_rise[2]) found = 1'b1;
        end
        chk("ch2 rise seen", 32'(found), 32'd1);
        a_clr = 4'b0100;
        tick();
        chk("ch2 set wins", 32'(a_evt[2]), 32'd1);
        a_clr = 4'hF;
        tick();
        chk("clear all evt", 32'(a_evt), 32'd0);
        chk("clear evt_any", 32'(a_any), 32'd0);
        a_clr = 4'h0;

        // ch3 reset at debounce count 10 aborts the transition
        a_sig = 4'hF;
        repeat (25) tick();
        a_sig[3] = 1'b0;
        repeat (12) tick();
        chk("ch3 pending level", 32'(a_lvl[3]), 32'd1);
        a_rst_n = 1'b0;
        a_sig   = 4'hF;
        tick();
        a_rst_n = 1'b1;
        chk("abort reset state", {a_lvl, a_rise, a_fall, a_evt}, {4'hF, 12'h0});
        nr = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_rise != 4'h0 || a_fall != 4'h0 || a_lvl != 4'hF || a_evt != 4'h0) nr++;
        end
        chk("abort no flag cycles", 32'(nr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
